// File: rtl/acc_multi_dispatcher.sv
// Speculative in-order dispatcher from the issue stage to NrAcc accelerator ports, with
// per-port outstanding throttling and round-robin merging of responses onto one writeback port.
module acc_multi_dispatcher #(
    parameter int unsigned NrAcc          = 2,
    parameter int unsigned QueueDepth     = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned NrSbEntries    = 8,
    parameter int unsigned XLEN           = 64,
    localparam int unsigned TransIdBits   = $clog2(NrSbEntries),
    localparam int unsigned SelBits       = (NrAcc > 1) ? $clog2(NrAcc) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                acc_cons_en_i,
    input  logic [2:0]                          fcsr_frm_i,
    input  logic                                issue_valid_i,
    output logic                                issue_ready_o,
    input  logic [TransIdBits-1:0]              issue_trans_id_i,
    input  logic [31:0]                         issue_insn_i,
    input  logic [XLEN-1:0]                     issue_rs1_i,
    input  logic [XLEN-1:0]                     issue_rs2_i,
    input  logic [SelBits-1:0]                  issue_sel_i,
    input  logic                                commit_i,
    input  logic [TransIdBits-1:0]              commit_trans_id_i,
    input  logic                                no_st_pending_i,
    output logic [NrAcc-1:0]                    req_valid_o,
    input  logic [NrAcc-1:0]                    req_ready_i,
    output logic [31:0]                         req_insn_o,
    output logic [XLEN-1:0]                     req_rs1_o,
    output logic [XLEN-1:0]                     req_rs2_o,
    output logic [2:0]                          req_frm_o,
    output logic [TransIdBits-1:0]              req_trans_id_o,
    output logic                                req_store_pending_o,
    input  logic [NrAcc-1:0]                    resp_valid_i,
    input  logic [NrAcc-1:0][TransIdBits-1:0]   resp_trans_id_i,
    input  logic [NrAcc-1:0][XLEN-1:0]          resp_result_i,
    input  logic [NrAcc-1:0]                    resp_error_i,
    output logic [NrAcc-1:0]                    resp_ready_o,
    output logic                                wb_valid_o,
    output logic [TransIdBits-1:0]              wb_trans_id_o,
    output logic [XLEN-1:0]                     wb_result_o,
    output logic                                wb_ex_valid_o,
    output logic                                flush_undisp_o
);
    localparam int unsigned CntBits   = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrBits   = $clog2(QueueDepth);
    localparam int unsigned UsageBits = $clog2(QueueDepth + 1);

    logic [TransIdBits-1:0] q_tid  [QueueDepth];
    logic [31:0]            q_insn [QueueDepth];
    logic [XLEN-1:0]        q_rs1  [QueueDepth];
    logic [XLEN-1:0]        q_rs2  [QueueDepth];
    logic [SelBits-1:0]     q_sel  [QueueDepth];

    logic [PtrBits-1:0]     rd_q, wr_q;
    logic [UsageBits-1:0]   usage_q;
    logic [NrSbEntries-1:0] pending_q, pending_d, ready_q, ready_d;
    logic [CntBits-1:0]     outstanding_q [NrAcc];
    logic [SelBits-1:0]     rr_q;

    logic [TransIdBits-1:0] head_tid;
    logic [SelBits-1:0]     head_sel;
    logic                   head_committed, eligible, push, pop;
    logic                   grant_found, err_flush, clear_queue;
    logic [SelBits-1:0]     grant_idx;

    assign head_tid = q_tid[rd_q];
    assign head_sel = q_sel[rd_q];

    // Commit bypass lets the head dispatch in the same cycle its commit arrives.
    assign head_committed = ready_q[head_tid] ||
                            (commit_i && pending_q[commit_trans_id_i] &&
                             (commit_trans_id_i == head_tid));
    assign eligible = rst_ni && (usage_q != '0) && head_committed &&
                      (outstanding_q[head_sel] < CntBits'(MaxOutstanding));
    assign pop           = eligible && req_ready_i[head_sel];
    assign issue_ready_o = rst_ni && (usage_q < UsageBits'(QueueDepth));
    assign push          = issue_valid_i && issue_ready_o;

    always_comb begin
        for (int p = 0; p < NrAcc; p++) begin
            req_valid_o[p] = eligible && (head_sel == SelBits'(p));
        end
    end

    assign req_insn_o          = eligible ? q_insn[rd_q] : '0;
    assign req_rs1_o           = eligible ? q_rs1[rd_q] : '0;
    assign req_rs2_o           = eligible ? q_rs2[rd_q] : '0;
    assign req_trans_id_o      = eligible ? head_tid : '0;
    assign req_frm_o           = eligible ? fcsr_frm_i : '0;
    assign req_store_pending_o = eligible && acc_cons_en_i && !no_st_pending_i;

    always_comb begin : arb
        logic [SelBits-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NrAcc; i++) begin
            cand = SelBits'((32'(rr_q) + 32'(i)) % 32'(NrAcc));
            if (rst_ni && !grant_found && resp_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NrAcc; p++) begin
            resp_ready_o[p] = grant_found && (grant_idx == SelBits'(p));
        end
    end

    assign err_flush      = grant_found && resp_error_i[grant_idx];
    assign clear_queue    = flush_i || err_flush;
    assign wb_valid_o     = grant_found;
    assign wb_trans_id_o  = grant_found ? resp_trans_id_i[grant_idx] : '0;
    assign wb_result_o    = grant_found ? resp_result_i[grant_idx] : '0;
    assign wb_ex_valid_o  = err_flush;
    assign flush_undisp_o = rst_ni && clear_queue;

    always_comb begin
        pending_d = pending_q;
        ready_d   = ready_q;
        if (commit_i && pending_q[commit_trans_id_i]) begin
            pending_d[commit_trans_id_i] = 1'b0;
            ready_d[commit_trans_id_i]   = 1'b1;
        end
        if (pop) ready_d[head_tid] = 1'b0;
        if (push) pending_d[issue_trans_id_i] = 1'b1;
        // Committed-but-flushed work keeps its ready bit; only an error drops it.
        if (clear_queue) pending_d = '0;
        if (err_flush) ready_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_tid[wr_q]  <= issue_trans_id_i;
            q_insn[wr_q] <= issue_insn_i;
            q_rs1[wr_q]  <= issue_rs1_i;
            q_rs2[wr_q]  <= issue_rs2_i;
            q_sel[wr_q]  <= issue_sel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q      <= '0;
            wr_q      <= '0;
            usage_q   <= '0;
            pending_q <= '0;
            ready_q   <= '0;
            rr_q      <= '0;
            for (int p = 0; p < NrAcc; p++) outstanding_q[p] <= '0;
        end else begin
            pending_q <= pending_d;
            ready_q   <= ready_d;
            if (clear_queue) begin
                rd_q    <= '0;
                wr_q    <= '0;
                usage_q <= '0;
            end else begin
                if (push) wr_q <= (wr_q == PtrBits'(QueueDepth - 1)) ? '0 : wr_q + PtrBits'(1);
                if (pop) rd_q <= (rd_q == PtrBits'(QueueDepth - 1)) ? '0 : rd_q + PtrBits'(1);
                if (push && !pop) usage_q <= usage_q + UsageBits'(1);
                else if (pop && !push) usage_q <= usage_q - UsageBits'(1);
            end
            if (grant_found) begin
                rr_q <= (grant_idx == SelBits'(NrAcc - 1)) ? '0 : grant_idx + SelBits'(1);
            end
            // A dispatch that coincides with an error flush still counts as in flight.
            for (int p = 0; p < NrAcc; p++) begin
                if (pop && (head_sel == SelBits'(p)) && !resp_ready_o[p]) begin
                    outstanding_q[p] <= outstanding_q[p] + CntBits'(1);
                end else if (resp_ready_o[p] && !(pop && (head_sel == SelBits'(p))) &&
                             (outstanding_q[p] != '0)) begin
                    outstanding_q[p] <= outstanding_q[p] - CntBits'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_acc_multi_dispatcher.sv
// Randomized bench for acc_multi_dispatcher: a queue-based reference model of issue, commit,
// dispatch, per-port accelerators and writeback arbitration predicts every output each cycle.
module tb_acc_multi_dispatcher;
    localparam int NrAcc = 2;
    localparam int QD    = 4;
    localparam int MO    = 2;
    localparam int NSB   = 8;
    localparam int XL    = 64;
    localparam int TB    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst_n, flush, cons_en, issue_valid, issue_ready, commit, no_st;
    logic [2:0]                 frm;
    logic [TB-1:0]              issue_tid, commit_tid;
    logic [31:0]                issue_insn;
    logic [XL-1:0]              issue_rs1, issue_rs2;
    logic [0:0]                 issue_sel;
    logic [NrAcc-1:0]           req_valid, req_ready, resp_valid, resp_err, resp_ready;
    logic [31:0]                req_insn;
    logic [XL-1:0]              req_rs1, req_rs2, wb_result;
    logic [2:0]                 req_frm;
    logic [TB-1:0]              req_tid, wb_tid;
    logic                       req_st_pend, wb_valid, wb_ex, flush_undisp;
    logic [NrAcc-1:0][TB-1:0]   resp_tid;
    logic [NrAcc-1:0][XL-1:0]   resp_result;

    acc_multi_dispatcher #(
        .NrAcc(NrAcc), .QueueDepth(QD), .MaxOutstanding(MO), .NrSbEntries(NSB), .XLEN(XL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .acc_cons_en_i(cons_en),
        .fcsr_frm_i(frm), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_trans_id_i(issue_tid), .issue_insn_i(issue_insn), .issue_rs1_i(issue_rs1),
        .issue_rs2_i(issue_rs2), .issue_sel_i(issue_sel), .commit_i(commit),
        .commit_trans_id_i(commit_tid), .no_st_pending_i(no_st), .req_valid_o(req_valid),
        .req_ready_i(req_ready), .req_insn_o(req_insn), .req_rs1_o(req_rs1),
        .req_rs2_o(req_rs2), .req_frm_o(req_frm), .req_trans_id_o(req_tid),
        .req_store_pending_o(req_st_pend), .resp_valid_i(resp_valid),
        .resp_trans_id_i(resp_tid), .resp_result_i(resp_result), .resp_error_i(resp_err),
        .resp_ready_o(resp_ready), .wb_valid_o(wb_valid), .wb_trans_id_o(wb_tid),
        .wb_result_o(wb_result), .wb_ex_valid_o(wb_ex), .flush_undisp_o(flush_undisp)
    );

    typedef struct packed {
        logic [TB-1:0] tid;
        logic [31:0]   insn;
        logic [XL-1:0] rs1;
        logic [XL-1:0] rs2;
        logic [0:0]    sel;
    } ent_t;

    ent_t          mq[$];
    logic [TB-1:0] accq[NrAcc][$];
    bit [NSB-1:0]  pend, rdy;
    int            outs[NrAcc];
    int            rr;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit tid_free(input logic [TB-1:0] t);
        if (pend[t]) return 1'b0;
        foreach (mq[i]) if (mq[i].tid == t) return 1'b0;
        for (int p = 0; p < NrAcc; p++) foreach (accq[p][i]) if (accq[p][i] == t) return 1'b0;
        return 1'b1;
    endfunction

    task automatic gen(input int flush_pct, input int resp_pct, input int err_pct);
        int pl[$];
        int r;
        issue_valid = 1'b0;
        issue_tid   = TB'($urandom_range(NSB - 1));
        if ($urandom_range(99) < 60) begin
            for (int k = 0; k < 8; k++) begin
                logic [TB-1:0] t;
                t = TB'($urandom_range(NSB - 1));
                if (tid_free(t)) begin
                    issue_valid = 1'b1;
                    issue_tid   = t;
                    break;
                end
            end
        end
        issue_insn = $urandom;
        issue_rs1  = {$urandom, $urandom};
        issue_rs2  = {$urandom, $urandom};
        issue_sel  = 1'($urandom_range(1));
        flush      = ($urandom_range(99) < flush_pct);
        commit     = 1'b0;
        commit_tid = TB'($urandom_range(NSB - 1));
        if (!flush) begin
            r = $urandom_range(99);
            for (int t = 0; t < NSB; t++) if (pend[t]) pl.push_back(t);
            if (r < 10) commit = 1'b1;
            else if (r < 60 && pl.size() > 0) begin
                commit     = 1'b1;
                commit_tid = TB'(pl[$urandom_range(pl.size() - 1)]);
            end
        end
        frm     = 3'($urandom_range(7));
        cons_en = 1'($urandom_range(1));
        no_st   = 1'($urandom_range(1));
        for (int p = 0; p < NrAcc; p++) begin
            req_ready[p]   = ($urandom_range(99) < 70);
            resp_result[p] = {$urandom, $urandom};
            resp_err[p]    = 1'($urandom_range(1));
            resp_tid[p]    = TB'($urandom_range(NSB - 1));
            resp_valid[p]  = 1'b0;
            if (accq[p].size() > 0 && $urandom_range(99) < resp_pct) begin
                resp_valid[p] = 1'b1;
                resp_tid[p]   = accq[p][0];
                resp_err[p]   = ($urandom_range(99) < err_pct);
            end
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model past the next edge.
    task automatic step();
        ent_t h;
        int   exp_rv, g, p;
        bit   req_hs, push, errf;
        if (!rst_n) begin
            check("rst_issue_ready", 64'(issue_ready), 0);
            check("rst_req_valid", 64'(req_valid), 0);
            check("rst_resp_ready", 64'(resp_ready), 0);
            check("rst_wb_valid", 64'(wb_valid), 0);
            check("rst_wb_ex", 64'(wb_ex), 0);
            check("rst_flush_undisp", 64'(flush_undisp), 0);
            check("rst_store_pending", 64'(req_st_pend), 0);
            mq.delete();
            pend = '0;
            rdy  = '0;
            rr   = 0;
            for (int q = 0; q < NrAcc; q++) begin
                outs[q] = 0;
                accq[q].delete();
            end
            return;
        end
        check("issue_ready", 64'(issue_ready), 64'(mq.size() < QD));
        exp_rv = 0;
        h      = '0;
        if (mq.size() > 0) begin
            h = mq[0];
            if ((rdy[h.tid] || (commit && pend[commit_tid] && commit_tid == h.tid)) &&
                outs[h.sel] < MO) exp_rv = 1 << h.sel;
        end
        check("req_valid", 64'(req_valid), 64'(exp_rv));
        if (exp_rv != 0) begin
            check("req_insn", 64'(req_insn), 64'(h.insn));
            check("req_rs1", req_rs1, h.rs1);
            check("req_rs2", req_rs2, h.rs2);
            check("req_tid", 64'(req_tid), 64'(h.tid));
            check("req_frm", 64'(req_frm), 64'(frm));
            check("req_store_pending", 64'(req_st_pend), 64'(cons_en && !no_st));
        end
        g = -1;
        for (int i = 0; i < NrAcc; i++) begin
            p = (rr + i) % NrAcc;
            if (g < 0 && resp_valid[p]) g = p;
        end
        errf = (g >= 0) && resp_err[g];
        check("resp_ready", 64'(resp_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
        check("wb_valid", 64'(wb_valid), 64'(g >= 0));
        check("wb_ex_valid", 64'(wb_ex), 64'(errf));
        if (g >= 0) begin
            check("wb_tid", 64'(wb_tid), 64'(resp_tid[g]));
            check("wb_result", wb_result, resp_result[g]);
        end
        check("flush_undisp", 64'(flush_undisp), 64'(flush || errf));

        req_hs = (exp_rv != 0) && req_ready[h.sel];
        push   = issue_valid && (mq.size() < QD);
        if (req_hs) begin
            outs[h.sel]++;
            accq[h.sel].push_back(h.tid);
        end
        if (g >= 0) begin
            if (outs[g] > 0) outs[g]--;
            void'(accq[g].pop_front());
            rr = (g + 1) % NrAcc;
        end
        if (commit && pend[commit_tid]) begin
            pend[commit_tid] = 1'b0;
            rdy[commit_tid]  = 1'b1;
        end
        if (req_hs) begin
            rdy[h.tid] = 1'b0;
            void'(mq.pop_front());
        end
        if (push) begin
            pend[issue_tid] = 1'b1;
            mq.push_back('{tid: issue_tid, insn: issue_insn, rs1: issue_rs1, rs2: issue_rs2,
                           sel: issue_sel});
        end
        if (flush || errf) begin
            mq.delete();
            pend = '0;
        end
        if (errf) rdy = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        pend  = '0;
        rdy   = '0;
        rr    = 0;
        for (int q = 0; q < NrAcc; q++) outs[q] = 0;
        gen(0, 0, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            gen(20, 0, 0);
            issue_valid = 1'b1;
            cons_en     = 1'b1;
            no_st       = 1'b0;
            resp_valid  = '1;
            resp_err    = '1;
            #4;
            step();
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 4000; c++) begin
            rst_n = !(c == 2000 || c == 2001);
            if (c < 300) gen(0, 60, 0);
            else if (c < 600) gen(2, 15, 0);
            else gen(3, 50, 4);
            #4;
            step();
            @(posedge clk);
            #1;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
